// File: rtl/mult_seq_32.sv
// Sequential 32x32 shift-add multiplier: one iteration per clock, 64-bit product on HI/LO.
// Define MULT_SEQ_SIGNED_EN for two's-complement operands using radix-2 Booth recoding.

module rc_add_sub_32 (
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic        sna,
   output logic [31:0] s,
   output logic        co,
   output logic        ovf
);
   logic [32:0] c;
   logic [31:0] yb;

   // Subtract is x + ~y + 1: invert y and feed sna in as the carry.
   assign yb   = y ^ {32{sna}};
   assign c[0] = sna;

   genvar i;
   generate
      for (i = 0; i < 32; i++) begin : g_fa
         assign s[i]   = x[i] ^ yb[i] ^ c[i];
         assign c[i+1] = (x[i] & yb[i]) | (x[i] & c[i]) | (yb[i] & c[i]);
      end
   endgenerate

   assign co  = c[32];
   assign ovf = c[32] ^ c[31];
endmodule

module mult_seq_32 #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             BUSY,
   output logic             DONE
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mq;
   logic [WIDTH-1:0] acc;
   logic [5:0]       cnt;
   logic             accept;
   logic             last_iter;
   logic             add_en;
   logic             sna;
   logic [31:0]      sum;
   logic [31:0]      sum_sel;
   logic             top_bit;
   logic [WIDTH-1:0] acc_n;
   logic [WIDTH-1:0] mq_n;

   assign accept    = START && (state != S_BUSY);
   assign last_iter = (cnt == 6'd31);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  if (START) state_n = S_BUSY;
         S_BUSY:  if (last_iter) state_n = S_DONE;
         S_DONE:  state_n = START ? S_BUSY : S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

`ifdef MULT_SEQ_SIGNED_EN
   logic q_prev;
   logic ovf;

   rc_add_sub_32 u_add (
      .x   (acc),
      .y   (mcand),
      .sna (sna),
      .s   (sum),
      .co  (),
      .ovf (ovf)
   );

   // Booth pair {mq[0], q_prev}: 01 adds, 10 subtracts, 00/11 just shift.
   always_comb begin
      add_en  = (mq[0] != q_prev);
      sna     = mq[0] & ~q_prev;
      sum_sel = add_en ? sum : acc;
      // Sign of the 33-bit result survives overflow of the 32-bit sum.
      top_bit = add_en ? (sum[31] ^ ovf) : acc[31];
   end
`else
   logic co;

   rc_add_sub_32 u_add (
      .x   (acc),
      .y   (mcand),
      .sna (sna),
      .s   (sum),
      .co  (co),
      .ovf ()
   );

   always_comb begin
      add_en  = mq[0];
      sna     = 1'b0;
      sum_sel = add_en ? sum : acc;
      top_bit = add_en ? co : 1'b0;
   end
`endif

   assign acc_n = {top_bit, sum_sel[31:1]};
   assign mq_n  = {sum_sel[0], mq[31:1]};

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         mcand <= '0;
         mq    <= '0;
         acc   <= '0;
         cnt   <= '0;
         HI    <= '0;
         LO    <= '0;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
         q_prev <= 1'b0;
`endif
      end else begin
         BUSY <= (state_n == S_BUSY);
         DONE <= (state_n == S_DONE);
         if (accept) begin
            mcand <= A;
            mq    <= B;
            acc   <= '0;
            cnt   <= '0;
`ifdef MULT_SEQ_SIGNED_EN
            q_prev <= 1'b0;
`endif
         end else if (state == S_BUSY) begin
            acc <= acc_n;
            mq  <= mq_n;
            cnt <= cnt + 6'd1;
`ifdef MULT_SEQ_SIGNED_EN
            q_prev <= mq[0];
`endif
            // Product lands on the same edge as the final iteration.
            if (last_iter) begin
               HI <= acc_n;
               LO <= mq_n;
            end
         end
      end
   end
endmodule
